// File: rtl/mem_stage_if.sv
// Pipeline and data-SRAM signal bundle around the MEM stage.
// master = the stage itself, slave = EX/WB/SRAM side.
interface mem_stage_if #(
  parameter int MEM_DATA_W = 79,
  parameter int WB_DATA_W  = 74
);
  logic                  es_to_ms_valid;
  logic [MEM_DATA_W-1:0] es_to_ms_bus;
  logic                  ms_allowin;
  logic                  ms_to_ws_valid;
  logic                  ws_allowin;
  logic [WB_DATA_W-1:0]  ms_to_ws_bus;
  logic                  data_sram_req;
  logic                  data_sram_wr;
  logic [3:0]            data_sram_wstrb;
  logic [31:0]           data_sram_addr;
  logic [31:0]           data_sram_wdata;
  logic                  data_sram_addr_ok;
  logic                  data_sram_data_ok;
  logic [31:0]           data_sram_rdata;
  logic                  ms_excp;

  modport master (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
           data_sram_req, data_sram_wr, data_sram_wstrb,
           data_sram_addr, data_sram_wdata, ms_excp
  );

  modport slave (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
           data_sram_req, data_sram_wr, data_sram_wstrb,
           data_sram_addr, data_sram_wdata, ms_excp
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the req/addr_ok/data_ok SRAM port, aligns load data.
// Optional macro MISALIGN_CHK_EN: misaligned half/word accesses skip the SRAM and raise ms_excp.
module mem_stage #(
  parameter int MEM_DATA_W = 79,
  parameter int WB_DATA_W  = 74
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.master ms
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [MEM_DATA_W-1:0] bus_reg;
  logic [31:0]           rdata_reg;

  logic        reg_write, mem_read, mem_write;
  logic [3:0]  mem_to_reg;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] result, rs2;
  logic [1:0]  addr_lo;

  assign reg_write  = bus_reg[78];
  assign mem_to_reg = bus_reg[77:74];
  assign mem_read   = bus_reg[73];
  assign mem_write  = bus_reg[72];
  assign funct3     = bus_reg[71:69];
  assign rd         = bus_reg[68:64];
  assign result     = bus_reg[63:32];
  assign rs2        = bus_reg[31:0];
  assign addr_lo    = result[1:0];

  logic       accept, in_mem, in_excp, excp;
  logic [1:0] accept_state;

  assign in_mem = ms.es_to_ms_bus[73] | ms.es_to_ms_bus[72];

`ifdef MISALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
  endfunction

  assign in_excp = in_mem & is_misaligned(ms.es_to_ms_bus[71:69], ms.es_to_ms_bus[33:32]);
  assign excp    = (mem_read | mem_write) & is_misaligned(funct3, addr_lo);
`else
  assign in_excp = 1'b0;
  assign excp    = 1'b0;
`endif

  assign ms.ms_allowin = (state_reg == IDLE) | ((state_reg == DONE) & ms.ws_allowin);
  assign accept        = ms.es_to_ms_valid & ms.ms_allowin;
  // Trapped accesses never touch the SRAM and report straight away.
  assign accept_state  = (in_mem & ~in_excp) ? REQ : DONE;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = accept_state;
      REQ:     if (ms.data_sram_addr_ok) state_next = WAIT;
      WAIT:    if (ms.data_sram_data_ok) state_next = DONE;
      DONE:    if (ms.ws_allowin) state_next = accept ? accept_state : IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [31:0] shifted, load_data;

  always_comb begin
    shifted = ms.data_sram_rdata >> {addr_lo, 3'b000};
    case (funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      bus_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        bus_reg   <= ms.es_to_ms_bus;
        rdata_reg <= '0;
      end else if ((state_reg == WAIT) && ms.data_sram_data_ok && mem_read) begin
        rdata_reg <= load_data;
      end
    end
  end

  logic [3:0]  wstrb;
  logic [31:0] wdata;

  always_comb begin
    wstrb = 4'b0000;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00:   wstrb = 4'b0001 << addr_lo;
        2'b01:   wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        default: wstrb = 4'b1111;
      endcase
    end
  end

  // Each byte lane picks its slice of rs2 so narrow stores land on any lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata[8*gi +: 8] = (funct3[1:0] == 2'b00) ? rs2[7:0] :
                                (funct3[1:0] == 2'b01) ? rs2[8*(gi%2) +: 8] :
                                                         rs2[8*gi +: 8];
    end
  endgenerate

  logic [WB_DATA_W-1:0] ws_bus;
  assign ws_bus = {reg_write & ~excp, mem_to_reg, rd, result, rdata_reg};

  assign ms.data_sram_req   = (state_reg == REQ);
  assign ms.data_sram_wr    = mem_write;
  assign ms.data_sram_wstrb = wstrb;
  assign ms.data_sram_addr  = result;
  assign ms.data_sram_wdata = wdata;
  assign ms.ms_to_ws_valid  = (state_reg == DONE);
  assign ms.ms_to_ws_bus    = ws_bus;
  assign ms.ms_excp         = (state_reg == DONE) & excp;
endmodule
